// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display link.
// The display-driver side and the scan receiver both use this package.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h72;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h73;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  localparam logic [3:0] DIG_BLANK_N = 4'b1111;
  localparam logic [3:0] DIG_SEL_N [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  function automatic logic dig_one_cold(input logic [3:0] d);
    return ($countones(~d) == 1);
  endfunction

  function automatic logic [1:0] dig_index(input logic [3:0] d);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (d == DIG_SEL_N[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_receiver_decode.sv
// Inverse hex segment table: seg[6:0] (bit6=a .. bit0=g) back to a nibble.
// Anything outside the 16 hex glyphs is reported as not legal.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_receiver.sv
// Receive side of a multiplexed 4-digit 7-segment bus: settles each digit
// select interval, decodes the glyph and publishes a 16-bit value once confirmed.
module seg_scan_receiver
  import seg_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int CONFIRM    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  dig_n,
  output logic [15:0] value,
  output logic [3:0]  dp_out,
  output logic        valid,
  output logic        bad_pattern,
  output logic        bad_select
);

  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W:0] SETTLE_V = (CNT_W+1)'(SETTLE_CYC);
  localparam logic [2:0]     CONF_V   = 3'(CONFIRM);

  logic [7:0]       seg_p0, seg_p1, seg_p2;
  logic [3:0]       dig_p0, dig_p1, dig_p2;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W:0]   cur;
  logic             eval, take;
  logic             dig_chg, seg_chg, blank, sel_ok;
  logic [1:0]       sel_k;
  logic [3:0]       dec_nib;
  logic             dec_legal;
  logic [3:0]       mask, new_mask;
  logic [2:0]       conf_cnt, conf_inc;
  logic [3:0]       slot_nib [4];
  logic [3:0]       slot_dp;
  logic [15:0]      frame_nib;
  logic [3:0]       frame_dp;
  logic [19:0]      prev_frame;

  // p0/p1: two-flop synchronizers; p2: previous synchronized copy for change detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0 <= '0;
      seg_p1 <= '0;
      seg_p2 <= '0;
      dig_p0 <= DIG_BLANK_N;
      dig_p1 <= DIG_BLANK_N;
      dig_p2 <= DIG_BLANK_N;
    end else begin
      seg_p0 <= seg_in;
      seg_p1 <= seg_p0;
      seg_p2 <= seg_p1;
      dig_p0 <= dig_n;
      dig_p1 <= dig_p0;
      dig_p2 <= dig_p1;
    end
  end

  assign dig_chg = (dig_p1 != dig_p2);
  assign seg_chg = (seg_p1 != seg_p2);
  assign blank   = (dig_p1 == DIG_BLANK_N);
  assign sel_ok  = dig_one_cold(dig_p1);
  assign sel_k   = dig_index(dig_p1);

  seg_pattern_decode u_dec (
    .seg    (seg_p1[6:0]),
    .nibble (dec_nib),
    .legal  (dec_legal)
  );

  // The cycle that first sees a new select counts as stable cycle 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur       = '0;
    eval      = 1'b0;
    take      = 1'b0;
    case (state)
      ST_WAIT: begin
        if (!blank) begin
          eval = 1'b1;
          cur  = (CNT_W+1)'(1);
        end
      end
      ST_SETTLE: begin
        if (blank) begin
          state_nxt = ST_WAIT;
        end else begin
          eval = 1'b1;
          cur  = (dig_chg || seg_chg) ? (CNT_W+1)'(1) : ({1'b0, cnt} + (CNT_W+1)'(1));
        end
      end
      ST_HOLD: begin
        if (dig_chg) begin
          if (blank) begin
            state_nxt = ST_WAIT;
          end else begin
            eval = 1'b1;
            cur  = (CNT_W+1)'(1);
          end
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
    if (eval) begin
      if (cur >= SETTLE_V) begin
        take      = 1'b1;
        state_nxt = ST_HOLD;
      end else begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = cur[CNT_W-1:0];
      end
    end
  end

  // Candidate frame: stored slots with the digit being sampled now substituted.
  always_comb begin
    frame_nib = '0;
    frame_dp  = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == sel_k) begin
        frame_nib[4*i +: 4] = dec_nib;
        frame_dp[i]         = seg_p1[7];
      end else begin
        frame_nib[4*i +: 4] = slot_nib[i];
        frame_dp[i]         = slot_dp[i];
      end
    end
  end

  assign new_mask = mask | (4'b0001 << sel_k);
  assign conf_inc = ((conf_cnt != 3'd0) && ({frame_dp, frame_nib} == prev_frame))
                    ? (conf_cnt + 3'd1) : 3'd1;

  // Sample stage: errors take priority and never complete a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT;
      cnt         <= '0;
      mask        <= '0;
      conf_cnt    <= '0;
      value       <= '0;
      dp_out      <= '0;
      valid       <= 1'b0;
      bad_pattern <= 1'b0;
      bad_select  <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      valid       <= 1'b0;
      bad_pattern <= 1'b0;
      bad_select  <= 1'b0;
      if (take) begin
        if (!sel_ok) begin
          bad_select <= 1'b1;
          mask       <= '0;
          conf_cnt   <= '0;
        end else if (!dec_legal) begin
          bad_pattern <= 1'b1;
          mask        <= '0;
          conf_cnt    <= '0;
        end else if (new_mask == 4'hF) begin
          mask <= '0;
          if (conf_inc == CONF_V) begin
            conf_cnt <= '0;
            valid    <= 1'b1;
            value    <= frame_nib;
            dp_out   <= frame_dp;
          end else begin
            conf_cnt <= conf_inc;
          end
        end else begin
          mask <= new_mask;
        end
      end
    end
  end

  // Slot and previous-frame storage are qualified by mask/conf_cnt, so no reset.
  always_ff @(posedge clk) begin
    if (take && sel_ok && dec_legal) begin
      slot_nib[sel_k] <= dec_nib;
      slot_dp[sel_k]  <= seg_p1[7];
      if (new_mask == 4'hF) prev_frame <= {frame_dp, frame_nib};
    end
  end

endmodule
